// File: rtl/sdes_cipher_core_if.sv
// -----------------------------------------------------------------------------
// sdes_cipher_core_if
//   Request/response bundle between an S-DES block engine and its user.
//
//   Signals (all 8-bit blocks are [0:7] with bit 0 = S-DES bit 1 = MSB):
//     Start    request, sampled only while the engine is idle
//     Mode     0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1)
//     DataIn   plaintext or ciphertext block
//     Key1     round subkey K1 from the key generator
//     Key2     round subkey K2 from the key generator
//     Busy     high while a block is in flight
//     Done     one-cycle pulse, DataOut is new
//     DataOut  result block, held until the next completion
//
//   master: the requester (drives Start/Mode/DataIn/Key1/Key2)
//   slave : the cipher engine (drives Busy/Done/DataOut)
// -----------------------------------------------------------------------------
interface sdes_cipher_core_if;
  logic       Start;
  logic       Mode;
  logic [0:7] DataIn;
  logic [0:7] Key1;
  logic [0:7] Key2;
  logic       Busy;
  logic       Done;
  logic [0:7] DataOut;

  modport master (
    output Start, Mode, DataIn, Key1, Key2,
    input  Busy, Done, DataOut
  );

  modport slave (
    input  Start, Mode, DataIn, Key1, Key2,
    output Busy, Done, DataOut
  );
endinterface : sdes_cipher_core_if

// File: rtl/sdes_cipher_core.sv
// -----------------------------------------------------------------------------
// sdes_cipher_core
//   Iterative S-DES encrypt/decrypt engine. Accepts two round subkeys and one
//   8-bit block, then performs IP, fK(first key), SW, fK(second key), IP^-1
//   over three clock edges and reports the result with a one-cycle Done pulse.
//
//   Ports:
//     clk  rising-edge clock for all state
//     rst  synchronous, active-high reset
//     bus  sdes_cipher_core_if.slave (Start/Mode/DataIn/Key1/Key2 in,
//          Busy/Done/DataOut out)
//
//   Bit order: every block is [0:7], index 0 is the MSB and corresponds to
//   S-DES position 1, so a 1-indexed S-DES table entry p selects index p-1.
// -----------------------------------------------------------------------------
module sdes_cipher_core (
  input  logic               clk,
  input  logic               rst,
  sdes_cipher_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    R1   = 2'd1,
    R2   = 2'd2
  } state_e;

  typedef logic [0:7] blk_t;
  typedef logic [0:3] nib_t;

  // S-boxes flattened row-major; index is {row, col} where
  // row = {x1, x4} and col = {x2, x3} of the 4-bit input.
  localparam logic [1:0] S0_TBL [0:15] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };

  localparam logic [1:0] S1_TBL [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  // ---------------------------------------------------------------------------
  // Fixed permutations (pure wiring)
  // ---------------------------------------------------------------------------

  // IP = 2 6 3 1 4 8 5 7
  function automatic blk_t init_perm(input blk_t d);
    return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
  endfunction

  // IP^-1 = 4 1 3 5 7 2 8 6
  function automatic blk_t inv_init_perm(input blk_t d);
    return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
  endfunction

  // E/P on the right nibble = 4 1 2 3 2 3 4 1
  function automatic blk_t expand_perm(input nib_t r);
    return {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]};
  endfunction

  // P4 = 2 4 3 1
  function automatic nib_t p4(input nib_t s);
    return {s[1], s[3], s[2], s[0]};
  endfunction

  // SW exchanges the two nibbles.
  function automatic blk_t swap_halves(input blk_t d);
    return {d[4:7], d[0:3]};
  endfunction

  // fK(L, R, K) = (L xor P4(S0(..) || S1(..)), R)
  function automatic blk_t f_k(input blk_t st, input blk_t k);
    blk_t       x;
    logic [0:1] s0;
    logic [0:1] s1;
    nib_t       p;
    x  = expand_perm(st[4:7]) ^ k;
    s0 = S0_TBL[{x[0], x[3], x[1], x[2]}];
    s1 = S1_TBL[{x[4], x[7], x[5], x[6]}];
    p  = p4({s0, s1});
    return {st[0:3] ^ p, st[4:7]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  blk_t   data_q,  data_d;      // working block between rounds
  blk_t   kfirst_q,  kfirst_d;  // key for round 1 (already mode-ordered)
  blk_t   ksecond_q, ksecond_d; // key for round 2
  blk_t   dout_q,  dout_d;
  logic   done_q,  done_d;
  logic   busy_q,  busy_d;

  // One fK datapath shared by both rounds; only the key selection differs.
  blk_t round_key;
  blk_t round_out;

  assign round_key = (state_q == R2) ? ksecond_q : kfirst_q;
  assign round_out = f_k(data_q, round_key);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise a latch is inferred.
    state_d   = state_q;
    data_d    = data_q;
    kfirst_d  = kfirst_q;
    ksecond_d = ksecond_q;
    dout_d    = dout_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          data_d    = init_perm(bus.DataIn);
          // Decrypt simply runs the rounds with the subkeys reversed.
          kfirst_d  = bus.Mode ? bus.Key2 : bus.Key1;
          ksecond_d = bus.Mode ? bus.Key1 : bus.Key2;
          state_d   = R1;
        end
      end
      R1: begin
        data_d  = swap_halves(round_out);
        state_d = R2;
      end
      R2: begin
        // No SW after the final round.
        dout_d  = inv_init_perm(round_out);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Busy is registered from the upcoming state so it tracks R1/R2 exactly.
    busy_d = (state_d == R1) || (state_d == R2);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      kfirst_q  <= '0;
      ksecond_q <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      kfirst_q  <= kfirst_d;
      ksecond_q <= ksecond_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DataOut = dout_q;

endmodule : sdes_cipher_core

// File: tb/tb_sdes_cipher_core.sv
// -----------------------------------------------------------------------------
// tb_sdes_cipher_core
//   Scoreboard bench for sdes_cipher_core. The driver pushes the expected
//   result of each accepted block into a queue; a monitor pops and compares on
//   every Done pulse. Expected values come from fixed known-answer vectors and
//   from a table-driven S-DES model working on plain integers.
// -----------------------------------------------------------------------------
module tb_sdes_cipher_core;

  logic clk;
  logic rst;

  sdes_cipher_core_if ifc();

  sdes_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       prev_done = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: permutations as 1-indexed position tables on integers
  // ---------------------------------------------------------------------------
  int IP_T [8] = '{2, 6, 3, 1, 4, 8, 5, 7};
  int IPI_T[8] = '{4, 1, 3, 5, 7, 2, 8, 6};
  int EP_T [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
  int P4_T [8] = '{2, 4, 3, 1, 0, 0, 0, 0};
  int S0_M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1_M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  // Output bit i takes input position tbl[i] (1 = MSB of an n_in-bit value).
  function automatic int perm(input int v, input int n_in, input int tbl[8], input int n_out);
    int r;
    r = 0;
    for (int i = 0; i < n_out; i++) r = (r << 1) | ((v >> (n_in - tbl[i])) & 1);
    return r;
  endfunction

  function automatic int nbit(input int n, input int pos);
    return (n >> (4 - pos)) & 1;
  endfunction

  function automatic int fk_m(input int v, input int k);
    int l, r, x, hi, lo, s0, s1, p;
    l  = (v >> 4) & 15;
    r  = v & 15;
    x  = perm(r, 4, EP_T, 8) ^ k;
    hi = (x >> 4) & 15;
    lo = x & 15;
    s0 = S0_M[nbit(hi, 1) * 2 + nbit(hi, 4)][nbit(hi, 2) * 2 + nbit(hi, 3)];
    s1 = S1_M[nbit(lo, 1) * 2 + nbit(lo, 4)][nbit(lo, 2) * 2 + nbit(lo, 3)];
    p  = perm((s0 << 2) | s1, 4, P4_T, 4);
    return ((l ^ p) << 4) | r;
  endfunction

  function automatic logic [7:0] sdes_m(input int d, input int k1, input int k2, input bit mode);
    int t, ka, kb;
    ka = mode ? k2 : k1;
    kb = mode ? k1 : k2;
    t  = perm(d, 8, IP_T, 8);
    t  = fk_m(t, ka);
    t  = ((t & 15) << 4) | ((t >> 4) & 15);
    t  = fk_m(t, kb);
    return 8'(perm(t, 8, IPI_T, 8));
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares every Done against the scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (ifc.Done === 1'b1) begin
      check(!prev_done, "done_single_cycle", 1, 0);
      check(exp_q.size() != 0, "done_unexpected", int'(ifc.DataOut), 0);
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check(ifc.DataOut == e, "dataout", int'(ifc.DataOut), int'(e));
      end
    end
    prev_done = (ifc.Done === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Driver: call just after a negedge; returns at the negedge of the Done cycle
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [7:0] d, input logic [7:0] k1, input logic [7:0] k2,
                       input logic mode, input logic [7:0] exp);
    ifc.Start  = 1'b1;
    ifc.Mode   = mode;
    ifc.DataIn = d;
    ifc.Key1   = k1;
    ifc.Key2   = k2;
    exp_q.push_back(exp);
    @(negedge clk);
    ifc.Start = 1'b0;
    check(ifc.Busy == 1'b1, "busy_r1", int'(ifc.Busy), 1);
    check(ifc.Done == 1'b0, "done_r1", int'(ifc.Done), 0);
    @(negedge clk);
    check(ifc.Busy == 1'b1, "busy_r2", int'(ifc.Busy), 1);
    check(ifc.Done == 1'b0, "done_r2", int'(ifc.Done), 0);
    @(negedge clk);
    check(ifc.Busy == 1'b0, "busy_done", int'(ifc.Busy), 0);
    check(ifc.Done == 1'b1, "done_latency", int'(ifc.Done), 1);
  endtask

  localparam logic [7:0] K1_V = 8'b10100100;
  localparam logic [7:0] K2_V = 8'b01000011;
  localparam logic [7:0] PT_V = 8'b10010111;
  localparam logic [7:0] CT_V = 8'b00111000;

  initial begin
    logic [7:0] d, k1, k2, c;

    rst        = 1'b1;
    ifc.Start  = 1'b0;
    ifc.Mode   = 1'b0;
    ifc.DataIn = '0;
    ifc.Key1   = '0;
    ifc.Key2   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check(ifc.Busy == 1'b0, "reset_busy", int'(ifc.Busy), 0);
    check(ifc.Done == 1'b0, "reset_done", int'(ifc.Done), 0);
    check(ifc.DataOut == 8'h00, "reset_dataout", int'(ifc.DataOut), 0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer encrypt, then decrypt
    issue(PT_V, K1_V, K2_V, 1'b0, CT_V);
    @(negedge clk);
    check(ifc.DataOut == CT_V, "dataout_held", int'(ifc.DataOut), int'(CT_V));
    issue(CT_V, K1_V, K2_V, 1'b1, PT_V);
    @(negedge clk);

    // Back-to-back: second Start in the Done cycle of the first
    issue(PT_V, K1_V, K2_V, 1'b0, CT_V);
    issue(CT_V, K1_V, K2_V, 1'b1, PT_V);
    @(negedge clk);

    // Input stability: inputs change and Start pulses while busy
    ifc.Start  = 1'b1;
    ifc.Mode   = 1'b0;
    ifc.DataIn = PT_V;
    ifc.Key1   = K1_V;
    ifc.Key2   = K2_V;
    exp_q.push_back(CT_V);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check(ifc.Busy == 1'b1, "stab_busy", int'(ifc.Busy), 1);
      ifc.Start  = 1'b1;
      ifc.Mode   = 1'($urandom);
      ifc.DataIn = 8'($urandom);
      ifc.Key1   = 8'($urandom);
      ifc.Key2   = 8'($urandom);
    end
    @(negedge clk);
    ifc.Start = 1'b0;
    check(ifc.Done == 1'b1, "stab_done", int'(ifc.Done), 1);
    repeat (2) begin
      @(negedge clk);
      check(ifc.Busy == 1'b0, "stab_no_requeue", int'(ifc.Busy), 0);
    end
    check(ifc.DataOut == CT_V, "stab_result_held", int'(ifc.DataOut), int'(CT_V));

    // Reset mid-operation (asserted during R2)
    ifc.Start  = 1'b1;
    ifc.Mode   = 1'b1;
    ifc.DataIn = CT_V;
    @(negedge clk);
    ifc.Start = 1'b0;
    @(negedge clk);
    check(ifc.Busy == 1'b1, "abort_in_r2", int'(ifc.Busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check(ifc.Busy == 1'b0, "abort_busy", int'(ifc.Busy), 0);
    check(ifc.Done == 1'b0, "abort_done", int'(ifc.Done), 0);
    check(ifc.DataOut == 8'h00, "abort_dataout", int'(ifc.DataOut), 0);
    repeat (3) begin
      @(negedge clk);
      check(ifc.Done == 1'b0, "abort_no_done", int'(ifc.Done), 0);
    end
    issue(PT_V, K1_V, K2_V, 1'b0, CT_V);
    @(negedge clk);

    // Start and rst on the same edge: reset wins
    ifc.Start = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    ifc.Start = 1'b0;
    rst       = 1'b0;
    check(ifc.Busy == 1'b0, "rst_beats_start", int'(ifc.Busy), 0);
    @(negedge clk);
    check(ifc.Busy == 1'b0, "rst_beats_start_2", int'(ifc.Busy), 0);

    // Random round-trip
    for (int n = 0; n < 1000; n++) begin
      d  = 8'($urandom);
      k1 = 8'($urandom);
      k2 = 8'($urandom);
      issue(d, k1, k2, 1'b0, sdes_m(int'(d), int'(k1), int'(k2), 1'b0));
      c = ifc.DataOut;
      issue(c, k1, k2, 1'b1, d);
    end

    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sdes_cipher_core
